// File: rtl/j11bus.sv
// Bus target for the DCJ11 front end: routes each single-beat request to memory,
// the I/O page or an internal responder, and returns exactly one busack per request.
module j11bus #(
    parameter logic [21:0] MEMSIZE = 22'o17760000,
    parameter int          TIMEOUT = 64,
    parameter logic [15:0] PUCFG   = 16'o000001
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        busreq,
    input  logic        buswr,
    input  logic        busgp,
    input  logic        busirq,
    input  logic [21:0] busaddr,
    input  logic [15:0] buswdata,
    input  logic [1:0]  buswstrb,
    input  logic [1:0]  busbs,
    output logic        busack,
    output logic [15:0] busrdata,
    output logic        buserr,
    output logic        memreq,
    output logic        memwr,
    output logic [21:0] memaddr,
    output logic [15:0] memwdata,
    output logic [1:0]  memwstrb,
    input  logic        memack,
    input  logic [15:0] memrdata,
    output logic        ioreq,
    output logic        iowr,
    output logic [12:0] ioaddr,
    output logic [15:0] iowdata,
    output logic [1:0]  iowstrb,
    input  logic        ioack,
    input  logic [15:0] iordata,
    input  logic        ionxm,
    input  logic [15:0] irqvec,
    output logic        errvalid,
    output logic [21:0] erraddr,
    input  logic        errclr
);
    // The I/O page never starts below the architectural 22-bit I/O page base;
    // a smaller MEMSIZE opens an NXM hole between the two.
    localparam logic [21:0] IOPAGE = 22'o17760000;
    localparam logic [21:0] IOBASE = (MEMSIZE > IOPAGE) ? MEMSIZE : IOPAGE;
    localparam int          CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [21:0]   addr_q;
    logic [15:0]   data_q;
    logic          err_q;
    logic          is_io;
    logic          is_nxm;
    logic          err_evt;
    logic [21:0]   err_at;

    always_comb begin
        is_io  = (busbs == 2'b11) || (busaddr >= IOBASE);
        is_nxm = !is_io && (busaddr >= MEMSIZE);
    end

    always_comb begin
        err_evt = 1'b0;
        err_at  = addr_q;
        case (state)
            IDLE: if (busreq && !busirq && !busgp && is_nxm) begin
                err_evt = 1'b1;
                err_at  = busaddr;
            end
            MEM:  err_evt = !memack && (cnt == TLAST);
            IO:   err_evt = ioack ? ionxm : (cnt == TLAST);
            default: err_evt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            busack   <= 1'b0;
            busrdata <= '0;
            buserr   <= 1'b0;
            memreq   <= 1'b0;
            memwr    <= 1'b0;
            memaddr  <= '0;
            memwdata <= '0;
            memwstrb <= '0;
            ioreq    <= 1'b0;
            iowr     <= 1'b0;
            ioaddr   <= '0;
            iowdata  <= '0;
            iowstrb  <= '0;
            errvalid <= 1'b0;
            erraddr  <= '0;
        end else begin
            busack   <= 1'b0;
            busrdata <= '0;
            buserr   <= 1'b0;
            case (state)
                IDLE: if (busreq) begin
                    addr_q <= busaddr;
                    cnt    <= '0;
                    data_q <= '0;
                    err_q  <= 1'b0;
                    if (busirq) begin
                        data_q <= irqvec;
                        state  <= DONE;
                    end else if (busgp) begin
                        data_q <= buswr ? 16'd0 : PUCFG;
                        state  <= DONE;
                    end else if (is_io) begin
                        ioreq   <= 1'b1;
                        iowr    <= buswr;
                        ioaddr  <= busaddr[12:0];
                        iowdata <= buswdata;
                        iowstrb <= buswstrb;
                        state   <= IO;
                    end else if (is_nxm) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        memreq   <= 1'b1;
                        memwr    <= buswr;
                        memaddr  <= busaddr;
                        memwdata <= buswdata;
                        memwstrb <= buswstrb;
                        state    <= MEM;
                    end
                end
                MEM: begin
                    // An ack in the expiry cycle takes precedence over the timeout.
                    if (memack) begin
                        memreq <= 1'b0;
                        data_q <= memwr ? 16'd0 : memrdata;
                        state  <= DONE;
                    end else if (cnt == TLAST) begin
                        memreq <= 1'b0;
                        err_q  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IO: begin
                    if (ioack) begin
                        ioreq  <= 1'b0;
                        err_q  <= ionxm;
                        data_q <= (iowr || ionxm) ? 16'd0 : iordata;
                        state  <= DONE;
                    end else if (cnt == TLAST) begin
                        ioreq <= 1'b0;
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    busack   <= 1'b1;
                    busrdata <= data_q;
                    buserr   <= err_q;
                    cnt      <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A fresh error beats a simultaneous clear.
            if (err_evt && (!errvalid || errclr)) begin
                errvalid <= 1'b1;
                erraddr  <= err_at;
            end else if (errclr) begin
                errvalid <= 1'b0;
            end
        end
    end
endmodule
